// File: rtl/fetch_stage_ctrl_pkg.sv
// Shared widths, encodings and fetch-FSM state codes for the 16-bit pipeline front end.
package fetch_stage_ctrl_pkg;

   localparam int ADDR_W  = 16;
   localparam int INSTR_W = 16;

   localparam logic [15:0] NOP_INSTR   = 16'h0000;
   localparam logic [3:0]  HALT_OPCODE = 4'hF;

   typedef logic [1:0] fetch_state_t;

   localparam fetch_state_t ST_RUN  = 2'd0;
   localparam fetch_state_t ST_MISS = 2'd1;
   localparam fetch_state_t ST_HALT = 2'd2;

endpackage

// File: rtl/fetch_stage_ctrl_if_id_reg.sv
// IF/ID pipeline register: flush loads a bubble and overrides write-enable; otherwise
// the register holds when write-enable is low.
module if_id_reg #(
   parameter int                 ADDR_W    = 16,
   parameter int                 INSTR_W   = 16,
   parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               we_i,
   input  logic               flush_i,
   input  logic [INSTR_W-1:0] instr_i,
   input  logic [ADDR_W-1:0]  pc_plus2_i,
   output logic [INSTR_W-1:0] instr_o,
   output logic [ADDR_W-1:0]  pc_plus2_o,
   output logic               valid_o
);

   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [ADDR_W-1:0]  pc_plus2_q, pc_plus2_d;
   logic               valid_q, valid_d;

   always_comb begin
      instr_d    = instr_q;
      pc_plus2_d = pc_plus2_q;
      valid_d    = valid_q;
      if (flush_i) begin
         instr_d    = NOP_INSTR;
         pc_plus2_d = '0;
         valid_d    = 1'b0;
      end else if (we_i) begin
         instr_d    = instr_i;
         pc_plus2_d = pc_plus2_i;
         valid_d    = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_q    <= NOP_INSTR;
         pc_plus2_q <= '0;
         valid_q    <= 1'b0;
      end else begin
         instr_q    <= instr_d;
         pc_plus2_q <= pc_plus2_d;
         valid_q    <= valid_d;
      end
   end

   assign instr_o    = instr_q;
   assign pc_plus2_o = pc_plus2_q;
   assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage_ctrl.sv
// Fetch stage: PC register, RUN/MISS/HALT fetch FSM, miss counter and the IF/ID register.
// Priority each cycle is branch redirect, then hazard stall, then instruction-memory ready.
module fetch_stage_ctrl #(
   parameter int                 ADDR_W      = fetch_stage_ctrl_pkg::ADDR_W,
   parameter int                 INSTR_W     = fetch_stage_ctrl_pkg::INSTR_W,
   parameter logic [ADDR_W-1:0]  RESET_PC    = '0,
   parameter logic [INSTR_W-1:0] NOP_INSTR   = fetch_stage_ctrl_pkg::NOP_INSTR,
   parameter logic [3:0]         HALT_OPCODE = fetch_stage_ctrl_pkg::HALT_OPCODE
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               hazard_stall,
   input  logic               branch_taken,
   input  logic [ADDR_W-1:0]  branch_target,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               imem_ready,
   output logic [ADDR_W-1:0]  pc_out,
   output logic [INSTR_W-1:0] if_id_instr,
   output logic [ADDR_W-1:0]  if_id_pc_plus2,
   output logic               if_id_valid,
   output logic               halted,
   output logic [15:0]        miss_cnt
);

   import fetch_stage_ctrl_pkg::*;

   function automatic logic [ADDR_W-1:0] pc_inc2(input logic [ADDR_W-1:0] pc);
      return pc + ADDR_W'(2);
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   logic [ADDR_W-1:0] pc_q, pc_d;
   fetch_state_t      state_q, state_d;
   logic [15:0]       miss_cnt_q, miss_cnt_d;
   logic [ADDR_W-1:0] pc_plus2;
   logic              is_halt;
   logic              ifid_we, ifid_flush;

   assign pc_plus2 = pc_inc2(pc_q);
   assign is_halt  = (imem_rdata[INSTR_W-1 -: 4] == HALT_OPCODE);

   always_comb begin
      pc_d       = pc_q;
      state_d    = state_q;
      miss_cnt_d = miss_cnt_q;
      ifid_we    = 1'b0;
      ifid_flush = 1'b0;
      if (branch_taken) begin
         // Redirect abandons any outstanding miss and cancels a speculatively fetched HLT.
         pc_d       = branch_target;
         state_d    = ST_RUN;
         ifid_flush = 1'b1;
      end else if (hazard_stall) begin
         if (state_q == ST_MISS)
            miss_cnt_d = sat_inc(miss_cnt_q);
      end else if (state_q == ST_HALT) begin
         ifid_flush = 1'b1;
      end else if (imem_ready) begin
         ifid_we = 1'b1;
         if (is_halt) begin
            state_d = ST_HALT;
         end else begin
            pc_d    = pc_plus2;
            state_d = ST_RUN;
         end
      end else begin
         ifid_flush = 1'b1;
         state_d    = ST_MISS;
         miss_cnt_d = sat_inc(miss_cnt_q);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q       <= RESET_PC;
         state_q    <= ST_RUN;
         miss_cnt_q <= '0;
      end else begin
         pc_q       <= pc_d;
         state_q    <= state_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   // A miss keeps requesting through a stall so the memory does not drop the access.
   assign imem_req  = !rst && ((state_q == ST_MISS) || ((state_q == ST_RUN) && !hazard_stall));
   assign imem_addr = pc_q;
   assign pc_out    = pc_q;
   assign halted    = (state_q == ST_HALT);
   assign miss_cnt  = miss_cnt_q;

   if_id_reg #(
      .ADDR_W    (ADDR_W),
      .INSTR_W   (INSTR_W),
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id (
      .clk        (clk),
      .rst        (rst),
      .we_i       (ifid_we),
      .flush_i    (ifid_flush),
      .instr_i    (imem_rdata),
      .pc_plus2_i (pc_plus2),
      .instr_o    (if_id_instr),
      .pc_plus2_o (if_id_pc_plus2),
      .valid_o    (if_id_valid)
   );

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Scoreboard bench for fetch_stage_ctrl: a reference model queues per-cycle expectations,
// a monitor compares them, and scenario tasks add directed checks.
module tb_fetch_stage_ctrl;

   localparam logic [1:0] M_RUN = 2'd0, M_MISS = 2'd1, M_HALT = 2'd2;

   logic        clk = 1'b0;
   logic        rst;
   logic        hazard_stall, branch_taken, imem_ready;
   logic [15:0] branch_target, imem_rdata;
   logic        imem_req, if_id_valid, halted;
   logic [15:0] imem_addr, pc_out, if_id_instr, if_id_pc_plus2, miss_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        req;
      logic [15:0] addr;
      logic [15:0] pc;
      logic [15:0] instr;
      logic [15:0] pp2;
      logic        valid;
      logic        halted;
      logic [15:0] miss;
   } exp_t;

   exp_t sb_q[$];

   logic [15:0] m_pc, m_instr, m_pp2, m_miss;
   logic        m_valid;
   logic [1:0]  m_st;

   fetch_stage_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .hazard_stall   (hazard_stall),
      .branch_taken   (branch_taken),
      .branch_target  (branch_target),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .imem_ready     (imem_ready),
      .pc_out         (pc_out),
      .if_id_instr    (if_id_instr),
      .if_id_pc_plus2 (if_id_pc_plus2),
      .if_id_valid    (if_id_valid),
      .halted         (halted),
      .miss_cnt       (miss_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #10000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   // Monitor: request/address checked mid-cycle, registered state checked after the edge.
   always begin : monitor
      exp_t e;
      @(negedge clk);
      if (sb_q.size() != 0) begin
         e = sb_q[0];
         checks++;
         if (imem_req !== e.req) begin
            errors++;
            $display("FAIL sb_imem_req: got %0b expected %0b at %0t", imem_req, e.req, $time);
         end
         checks++;
         if (imem_addr !== e.addr) begin
            errors++;
            $display("FAIL sb_imem_addr: got %h expected %h at %0t", imem_addr, e.addr, $time);
         end
         @(posedge clk);
         #1;
         void'(sb_q.pop_front());
         checks++;
         if (pc_out !== e.pc) begin
            errors++;
            $display("FAIL sb_pc: got %h expected %h at %0t", pc_out, e.pc, $time);
         end
         checks++;
         if ({if_id_valid, if_id_instr, if_id_pc_plus2} !== {e.valid, e.instr, e.pp2}) begin
            errors++;
            $display("FAIL sb_if_id: got v=%0b i=%h p=%h expected v=%0b i=%h p=%h at %0t",
                     if_id_valid, if_id_instr, if_id_pc_plus2, e.valid, e.instr, e.pp2, $time);
         end
         checks++;
         if (halted !== e.halted) begin
            errors++;
            $display("FAIL sb_halted: got %0b expected %0b at %0t", halted, e.halted, $time);
         end
         checks++;
         if (miss_cnt !== e.miss) begin
            errors++;
            $display("FAIL sb_miss_cnt: got %h expected %h at %0t", miss_cnt, e.miss, $time);
         end
      end
   end

   task automatic model_reset();
      m_pc = 16'h0000; m_instr = 16'h0000; m_pp2 = 16'h0000;
      m_valid = 1'b0; m_st = M_RUN; m_miss = 16'h0000;
   endtask

   task automatic model_bubble();
      m_instr = 16'h0000; m_pp2 = 16'h0000; m_valid = 1'b0;
   endtask

   // Drive one cycle of inputs, queue the expected outcome, return 3 units after the edge.
   task automatic step(input logic s, input logic b, input logic [15:0] t,
                       input logic r, input logic [15:0] d);
      exp_t e;
      hazard_stall = s; branch_taken = b; branch_target = t; imem_ready = r; imem_rdata = d;
      e.req  = (m_st == M_MISS) || ((m_st == M_RUN) && !s);
      e.addr = m_pc;
      if (b) begin
         m_pc = t; model_bubble(); m_st = M_RUN;
      end else if (s) begin
         if (m_st == M_MISS && m_miss != 16'hFFFF) m_miss = m_miss + 16'd1;
      end else if (m_st == M_HALT) begin
         model_bubble();
      end else if (r) begin
         m_instr = d; m_pp2 = m_pc + 16'd2; m_valid = 1'b1;
         if (d[15:12] == 4'hF) m_st = M_HALT;
         else begin
            m_pc = m_pc + 16'd2; m_st = M_RUN;
         end
      end else begin
         model_bubble(); m_st = M_MISS;
         if (m_miss != 16'hFFFF) m_miss = m_miss + 16'd1;
      end
      e.pc = m_pc; e.instr = m_instr; e.pp2 = m_pp2; e.valid = m_valid;
      e.halted = (m_st == M_HALT); e.miss = m_miss;
      sb_q.push_back(e);
      @(posedge clk);
      #3;
   endtask

   task automatic test_reset();
      rst = 1'b1; hazard_stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0;
      imem_ready = 1'b0; imem_rdata = 16'h0;
      #2;
      checks++;
      if ({pc_out, if_id_instr, if_id_pc_plus2, if_id_valid, halted, miss_cnt, imem_req} !==
          {16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0}) begin
         errors++;
         $display("FAIL reset_state: got pc=%h i=%h p=%h v=%0b h=%0b m=%h req=%0b expected all zero",
                  pc_out, if_id_instr, if_id_pc_plus2, if_id_valid, halted, miss_cnt, imem_req);
      end
      @(posedge clk);
      #3;
      rst = 1'b0;
      model_reset();
      #1;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
         errors++;
         $display("FAIL reset_first_req: got req=%0b addr=%h expected req=1 addr=0000", imem_req, imem_addr);
      end
   endtask

   task automatic test_fetch();
      step(0, 0, 16'h0, 1, 16'h1234);
      checks++;
      if (pc_out !== 16'h0002 || if_id_instr !== 16'h1234 || if_id_pc_plus2 !== 16'h0002 || if_id_valid !== 1'b1) begin
         errors++;
         $display("FAIL fetch_first: got pc=%h i=%h p=%h v=%0b expected pc=0002 i=1234 p=0002 v=1",
                  pc_out, if_id_instr, if_id_pc_plus2, if_id_valid);
      end
      step(0, 0, 16'h0, 1, 16'h2345);
      checks++;
      if (pc_out !== 16'h0004 || if_id_instr !== 16'h2345 || if_id_pc_plus2 !== 16'h0004) begin
         errors++;
         $display("FAIL fetch_second: got pc=%h i=%h p=%h expected pc=0004 i=2345 p=0004",
                  pc_out, if_id_instr, if_id_pc_plus2);
      end
   endtask

   task automatic test_stall();
      for (int i = 0; i < 2; i++) begin
         step(1, 0, 16'h0, 1, 16'hBEEF);
         checks++;
         if (pc_out !== 16'h0004 || if_id_instr !== 16'h2345 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold: got pc=%h i=%h req=%0b expected pc=0004 i=2345 req=0",
                     pc_out, if_id_instr, imem_req);
         end
      end
      step(0, 0, 16'h0, 1, 16'h3456);
      checks++;
      if (pc_out !== 16'h0006 || if_id_instr !== 16'h3456) begin
         errors++;
         $display("FAIL stall_release: got pc=%h i=%h expected pc=0006 i=3456", pc_out, if_id_instr);
      end
   endtask

   task automatic test_miss();
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 16'h0, 0, 16'hDEAD);
         checks++;
         if (imem_addr !== 16'h0006 || if_id_valid !== 1'b0 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL miss_hold: got addr=%h v=%0b req=%0b expected addr=0006 v=0 req=1",
                     imem_addr, if_id_valid, imem_req);
         end
      end
      checks++;
      if (miss_cnt !== 16'd3) begin
         errors++;
         $display("FAIL miss_count: got %0d expected 3", miss_cnt);
      end
      step(0, 0, 16'h0, 1, 16'h4567);
      checks++;
      if (pc_out !== 16'h0008 || if_id_instr !== 16'h4567 || if_id_valid !== 1'b1 || if_id_pc_plus2 !== 16'h0008) begin
         errors++;
         $display("FAIL miss_resolve: got pc=%h i=%h v=%0b p=%h expected pc=0008 i=4567 v=1 p=0008",
                  pc_out, if_id_instr, if_id_valid, if_id_pc_plus2);
      end
   endtask

   task automatic test_branch_in_miss();
      step(0, 0, 16'h0, 0, 16'h0);
      step(1, 1, 16'h0040, 1, 16'hF000);
      checks++;
      if (pc_out !== 16'h0040 || if_id_valid !== 1'b0 || halted !== 1'b0) begin
         errors++;
         $display("FAIL branch_miss: got pc=%h v=%0b h=%0b expected pc=0040 v=0 h=0", pc_out, if_id_valid, halted);
      end
      step(0, 0, 16'h0, 1, 16'h1111);
      checks++;
      if (pc_out !== 16'h0042 || if_id_instr !== 16'h1111) begin
         errors++;
         $display("FAIL branch_resume: got pc=%h i=%h expected pc=0042 i=1111", pc_out, if_id_instr);
      end
   endtask

   task automatic test_halt();
      step(0, 1, 16'h0010, 0, 16'h0);
      step(0, 0, 16'h0, 1, 16'hF000);
      checks++;
      if (halted !== 1'b1 || pc_out !== 16'h0010 || if_id_instr !== 16'hF000 || if_id_valid !== 1'b1 || imem_req !== 1'b0) begin
         errors++;
         $display("FAIL halt_enter: got h=%0b pc=%h i=%h v=%0b req=%0b expected h=1 pc=0010 i=F000 v=1 req=0",
                  halted, pc_out, if_id_instr, if_id_valid, imem_req);
      end
      step(0, 0, 16'h0, 1, 16'h2222);
      checks++;
      if (halted !== 1'b1 || pc_out !== 16'h0010 || if_id_valid !== 1'b0) begin
         errors++;
         $display("FAIL halt_bubble: got h=%0b pc=%h v=%0b expected h=1 pc=0010 v=0", halted, pc_out, if_id_valid);
      end
      step(0, 1, 16'h0020, 0, 16'h0);
      checks++;
      if (halted !== 1'b0 || pc_out !== 16'h0020) begin
         errors++;
         $display("FAIL halt_exit: got h=%0b pc=%h expected h=0 pc=0020", halted, pc_out);
      end
   endtask

   task automatic test_wrap();
      step(0, 1, 16'hFFFE, 0, 16'h0);
      step(0, 0, 16'h0, 1, 16'h1357);
      checks++;
      if (pc_out !== 16'h0000 || if_id_pc_plus2 !== 16'h0000 || if_id_instr !== 16'h1357 || if_id_valid !== 1'b1) begin
         errors++;
         $display("FAIL pc_wrap: got pc=%h p=%h i=%h v=%0b expected pc=0000 p=0000 i=1357 v=1",
                  pc_out, if_id_pc_plus2, if_id_instr, if_id_valid);
      end
   endtask

   task automatic test_reset_mid_miss();
      step(0, 0, 16'h0, 0, 16'h0);
      hazard_stall = 1'b1;
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if (pc_out !== 16'h0000 || miss_cnt !== 16'h0000 || if_id_valid !== 1'b0 || imem_req !== 1'b0 || halted !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_miss: got pc=%h m=%h v=%0b req=%0b h=%0b expected all zero",
                  pc_out, miss_cnt, if_id_valid, imem_req, halted);
      end
      hazard_stall = 1'b0;
      @(posedge clk);
      #3;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_saturation();
      int guard;
      guard = 0;
      while (m_miss != 16'hFFFF && guard < 70000) begin
         step(0, 0, 16'h0, 0, 16'h0);
         guard++;
      end
      step(0, 0, 16'h0, 0, 16'h0);
      step(1, 0, 16'h0, 0, 16'h0);
      checks++;
      if (miss_cnt !== 16'hFFFF) begin
         errors++;
         $display("FAIL miss_saturate: got %h expected FFFF", miss_cnt);
      end
      step(0, 0, 16'h0, 1, 16'h5A5A);
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_stall();
      test_miss();
      test_branch_in_miss();
      test_halt();
      test_wrap();
      test_reset_mid_miss();
      test_saturation();
      #10;
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_stage_ctrl.md
Name: fetch_stage_ctrl

Overview:
- Front end of the 5-stage 16-bit pipeline.
- Owns the PC register and the IF/ID pipeline register, issues instruction-memory fetches, and tolerates multi-cycle instruction-memory misses.
- Acts on the stall request from hazard detection (hold PC and IF/ID) and the branch redirect from ID (squash IF/ID, reload PC).
- Detects HLT at fetch and freezes the PC.

Parameters:
- ADDR_W, 16, PC / instruction address width.
- INSTR_W, 16, instruction width.
- RESET_PC, 16'h0000, PC value after reset.
- NOP_INSTR, 16'h0000, encoding loaded into IF/ID for a bubble.
- HALT_OPCODE, 4'hF, instr[15:12] value identifying HLT.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- hazard_stall  in  1  1 = hold PC and IF/ID this cycle (load-use stall).
- branch_taken  in  1  1 = branch/jump in ID resolved taken; redirect.
- branch_target  in  ADDR_W  redirect address, valid when branch_taken=1.
- imem_req  out  1  fetch request.
- imem_addr  out  ADDR_W  fetch address, always equals pc_out.
- imem_rdata  in  INSTR_W  fetched instruction, valid when imem_ready=1.
- imem_ready  in  1  fetch data valid this cycle; 0 = miss in progress.
- pc_out  out  ADDR_W  current PC.
- if_id_instr  out  INSTR_W  IF/ID instruction.
- if_id_pc_plus2  out  ADDR_W  IF/ID PC+2.
- if_id_valid  out  1  0 = IF/ID holds a bubble.
- halted  out  1  HLT fetched and latched; PC frozen.
- miss_cnt  out  16  count of miss cycles, saturating at 16'hFFFF.

Behaviour:
- Reset (async, active-high): PC=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc_plus2=0, if_id_valid=0, state=RUN, halted=0, miss_cnt=0. imem_req is 1 on the first cycle after reset deasserts.
- FSM states: RUN, MISS, HALT. halted = (state==HALT).
- Per-cycle priority: branch_taken > hazard_stall > imem_ready.
- branch_taken=1, any state:
  - PC <= branch_target; IF/ID <= bubble; state <= RUN.
  - An in-flight miss is abandoned; the data is ignored.
  - A speculatively fetched HLT is cancelled, so HALT -> RUN.
- hazard_stall=1 (no branch):
  - PC, IF/ID and state hold.
  - imem_req=0 in RUN/HALT; imem_req=1 in MISS (keeps the miss alive), but imem_ready is ignored that cycle.
  - miss_cnt still increments if in MISS.
- RUN, no stall/branch: imem_req=1, imem_addr=PC.
  - imem_ready=1: IF/ID <= {imem_rdata, PC+2, valid=1}.
    - If imem_rdata[15:12]==HALT_OPCODE: PC holds, state <= HALT.
    - Otherwise: PC <= PC+2.
  - imem_ready=0: IF/ID <= bubble, PC holds, state <= MISS, miss_cnt++.
- MISS: imem_req=1, same address.
  - imem_ready=1: identical to the RUN/ready case, including HLT detection; state <= RUN or HALT.
  - Else: IF/ID <= bubble, miss_cnt++.
- HALT: imem_req=0, PC frozen, IF/ID <= bubble every cycle. Exits only on rst or branch_taken.
- Arithmetic: PC+2 wraps modulo 2^ADDR_W (16'hFFFE -> 16'h0000). miss_cnt saturates at all-ones.
- Fetch latency: instruction at PC appears in IF/ID on the edge where imem_ready=1 (zero extra cycles on a hit).
- Reset asserted mid-miss or mid-stall: immediate return to reset values; no residual request.

Decomposition:
- Shared package: ADDR_W, INSTR_W, NOP_INSTR, HALT_OPCODE, fetch-state enum {RUN, MISS, HALT}.
- One natural sub-module: if_id_reg, the IF/ID register with hold (write-enable) and flush (bubble load) inputs; flush dominates hold.
- PC register and FSM stay in fetch_stage_ctrl.

Test Plan:
- Reset, then imem_ready=1 with instrs 16'h1234, 16'h2345 -> pc_out 0,2,4; IF/ID valid with pc_plus2 2,4.
- hazard_stall=1 for 2 cycles at PC=4 -> PC stays 4, IF/ID unchanged, imem_req=0; release -> fetch resumes at 4.
- imem_ready=0 for 3 cycles at PC=6 -> state MISS, if_id_valid=0, miss_cnt=3, imem_addr=6 throughout; then ready -> IF/ID loads, PC=8.
- branch_taken=1, target 16'h0040, during a MISS with hazard_stall=1 -> PC=0x40, IF/ID bubble, state RUN.
- Fetch 16'hF000 at PC=0x10 -> halted=1, PC stays 0x10, IF/ID valid with HLT one cycle then bubbles. Next cycle branch_taken to 0x20 -> halted=0, PC=0x20.
- Run PC up to 16'hFFFE with ready -> next PC 16'h0000, if_id_pc_plus2=0. Preload miss_cnt to 16'hFFFF, miss one more cycle -> miss_cnt stays 16'hFFFF.
